alu4_seq: RTL
=============

# alu4_seq

Sequential 4-bit ALU stage: a valid/ready handshake captures an opcode and two 4-bit operands, computes the result with add, subtract, negate, logic or multi-bit shift, and holds a registered result with carry, overflow and zero flags until downstream accepts it. The arithmetic matches the combinational ripple-add, two's-complement, subtract and logical-shift-right units. Shifts iterate one bit per cycle, so a shift by n costs n cycles. The block sits between the operand/opcode source and the result consumer (register file writeback or display).

## Interface
- No parameters; datapath width fixed at 4 bits.
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, synchronous, active-high: one clock; reset is synchronous and active-high.
- in_valid  in  1  opcode/a/b valid.
- in_ready  out  1  block can accept an operation.
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SRL, 110 SLL, 111 NEG.
- a  in  4  operand A.
- b  in  4  operand B; for SRL/SLL only b[1:0] is used as shift amount n (0..3).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  downstream accepts result.
- result  out  4  registered result.
- cout  out  1  carry/borrow/shifted-out bit.
- of  out  1  signed overflow.
- zero  out  1  result == 4'b0000.

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- in_ready = (state == IDLE) && !rst. Accept = in_valid && in_ready at a rising edge.
- IDLE, accept, non-shift op, or shift with n == 0: compute, register result/flags, go to DONE.
- IDLE, accept, SRL/SLL with n ≥ 1: acc ← a, cnt ← n, latch direction, go to SHIFT.
- SHIFT: each edge shifts acc by one bit with zero fill, captures the bit shifted out into cout, and decrements cnt. The edge where cnt reaches 0 writes result and goes to DONE.
- DONE: out_valid = 1; result and flags held stable. When out_ready = 1, go to IDLE and clear out_valid.
- in_valid is ignored outside IDLE. Inputs need only be stable at the accept edge.
- Arithmetic, modulo 16:
  - ADD: {cout, result} = a + b. of = (a[3] == b[3]) && (result[3] != a[3]).
  - SUB: {cout, result} = a + ~b + 1, so cout = 1 means no borrow. of = (a[3] != b[3]) && (result[3] != a[3]).
  - NEG: result = ~a + 1. cout = (a == 0). of = (a == 4'b1000).
  - AND/OR/XOR: bitwise; cout = 0, of = 0.
  - SRL/SLL: logical shift, zero fill. cout = last bit shifted out, or 0 when n = 0. of = 0.
  - zero is computed from the final result for every op.
- Reset in any state, including mid-SHIFT or DONE with out_ready low: pending operation is discarded and no partial result is presented.

## Timing
- Reset values: out_valid 0, result 4'b0000, cout 0, of 0, zero 0 (zero is registered; forced 0 during reset), state IDLE. in_ready is 0 while rst is high and 1 on the first cycle after.
- Accept at edge E:
  - Non-shift op, or shift with n = 0: out_valid = 1 after E (latency 1).
  - Shift with n ≥ 1: out_valid = 1 after E + n (latency n + 1).
- Result handshake at edge F (out_valid && out_ready): out_valid = 0 and in_ready = 1 after F. Next accept is possible at F + 1, so best-case throughput is one op per 2 cycles.
- out_valid, result and flags never change while out_valid = 1 and out_ready = 0.
- out_ready held high continuously: DONE lasts exactly one cycle.

## Test plan
- Reset: assert rst 2 cycles mid-SHIFT (SLL a=4'b0001, n=3, released after 1 shift) → out_valid 0, result 0, flags 0, in_ready 1 the cycle after rst drops; no stale result appears.
- ADD overflow: a=4'b0111, b=4'b0001 → result 4'b1000, cout 0, of 1, zero 0, out_valid 1 cycle after accept. ADD a=4'b1111, b=4'b0001 → result 0, cout 1, of 0, zero 1.
- SUB/NEG: SUB a=4'b0011, b=4'b0101 → result 4'b1110, cout 0, of 0. NEG a=4'b1000 → result 4'b1000, of 1, cout 0. NEG a=0 → result 0, cout 1, zero 1.
- Multi-cycle shift: SRL a=4'b1011, b=2'b11 → out_valid exactly 4 cycles after accept, result 4'b0001, cout 0. SLL a=4'b1011, n=1 → result 4'b0110, cout 1, latency 2. SRL with n=0 → result = a, cout 0, latency 1.
- Backpressure: out_ready low for 5 cycles after an AND result → outputs stable, in_ready 0, an in_valid pulse during the stall is ignored. Raise out_ready → in_ready 1 the next cycle.
- Back-to-back: in_valid and out_ready held high, 8 random ops checked against a reference model → one result per 2 cycles for non-shift ops, no operation dropped or duplicated.

Source files
------------

// File: rtl/alu4_seq.sv
// alu4_seq: handshaked 4-bit ALU stage with one-bit-per-cycle iterative shifts and registered result/flags
module alu4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] opcode,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] result,
  output logic       cout,
  output logic       of,
  output logic       zero
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [3:0] acc, r, sh_nxt;
  logic [1:0] cnt;
  logic dir, c, o, is_sh;
  assign in_ready = state == IDLE && !rst;
  assign is_sh = opcode == 3'b101 || opcode == 3'b110;
  assign sh_nxt = dir ? {acc[2:0], 1'b0} : {1'b0, acc[3:1]};
  always_comb begin
    r = 4'b0;
    c = 1'b0;
    o = 1'b0;
    case (opcode)
      3'b000: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        o = a[3] == b[3] && r[3] != a[3];
      end
      3'b001: begin
        {c, r} = {1'b0, a} + {1'b0, ~b} + 5'd1;
        o = a[3] != b[3] && r[3] != a[3];
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b111: begin
        r = ~a + 4'd1;
        c = a == 4'b0000;
        o = a == 4'b1000;
      end
      default: r = a;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= 4'b0;
      cout <= 1'b0;
      of <= 1'b0;
      zero <= 1'b0;
      acc <= 4'b0;
      cnt <= 2'b0;
      dir <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (is_sh && b[1:0] != 2'b00) begin
            acc <= a;
            cnt <= b[1:0];
            dir <= opcode[1];
            state <= SHIFT;
          end else begin
            result <= r;
            cout <= c;
            of <= o;
            zero <= r == 4'b0000;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        SHIFT: begin
          acc <= sh_nxt;
          cout <= dir ? acc[3] : acc[0];
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            result <= sh_nxt;
            of <= 1'b0;
            zero <= sh_nxt == 4'b0000;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
